// File: rtl/mem_pkg.sv
// mem_pkg: shared line-state encoding, widths and cache FSM states for memory_subsystem initiators.
package mem_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {I = 2'b00, M = 2'b01, S = 2'b10} coherency_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} cache_fsm_t;
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped tag/data/state storage, combinational read, synchronous write.
module cache_line_array import mem_pkg::*; #(
    parameter int NUM_LINES = 8,
    parameter int TAG_W = 11,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
    output logic [1:0]                   rd_state,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
    input  logic [1:0]                   wr_state,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [DATA_W-1:0]            wr_data
);
    coherency_t        state_q [NUM_LINES];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [DATA_W-1:0] data_q  [NUM_LINES];

    assign rd_state = state_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINES; i++) state_q[i] <= I;
        end else if (wr_en) begin
            state_q[wr_idx] <= coherency_t'(wr_state);
        end
    end

    // Tags and data carry no reset; state alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/proc_cache_requester.sv
// proc_cache_requester: per-processor write-back, direct-mapped cache issuing read/write
// transactions to memory_subsystem with a response timeout.
module proc_cache_requester import mem_pkg::*; #(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int CNT_W = $clog2(TIMEOUT);

    cache_fsm_t        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              gap_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        rd_state;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit, cmd, resp, tmo;
    logic              wr_en;
    coherency_t        wr_state;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;

    assign idx  = addr_q[IDX_W-1:0];
    assign tag  = addr_q[ADDR_W-1:IDX_W];
    assign hit  = rd_state != I && rd_tag == tag;
    // gap_q forces one idle command cycle between a writeback and its fill.
    assign cmd  = (state_q == WB || state_q == FILL) && !gap_q;
    assign resp = cmd && mem_resp;
    assign tmo  = cmd && !mem_resp && cnt_q == CNT_W'(TIMEOUT - 1);

    cache_line_array #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lines (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (idx),
        .rd_state (rd_state),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_state (wr_state),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        wr_state = I;
        wr_tag   = tag;
        wr_data  = rd_data;
        unique case (state_q)
            IDLE:   state_d = cpu_valid ? LOOKUP : IDLE;
            LOOKUP: begin
                state_d  = hit ? DONE : (rd_state == M ? WB : FILL);
                wr_en    = hit && we_q;
                wr_state = M;
                wr_data  = wdata_q;
            end
            WB: begin
                state_d = resp ? FILL : (tmo ? DONE : WB);
                wr_en   = resp;
                wr_tag  = rd_tag;
            end
            // A fill timeout invalidates the target so a dropped S victim never lingers.
            FILL: begin
                state_d  = resp || tmo ? DONE : FILL;
                wr_en    = resp || tmo;
                wr_state = resp ? (we_q ? M : S) : I;
                wr_data  = we_q ? wdata_q : mem_rdata;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= state_q == WB && resp;
            cnt_q   <= (state_d != state_q || !cmd) ? '0 : cnt_q + 1'b1;
            if (state_q == IDLE && cpu_valid) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                err_q   <= 1'b0;
            end
            if (state_q == LOOKUP && hit && !we_q) rdata_q <= rd_data;
            if (state_q == FILL && resp && !we_q) rdata_q <= mem_rdata;
            if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign cpu_ready     = state_q == IDLE;
    assign cpu_done      = state_q == DONE;
    assign cpu_rdata     = rdata_q;
    assign cpu_err       = cpu_done && err_q;
    assign mem_write_req = cmd && state_q == WB;
    assign mem_read_req  = cmd && state_q == FILL;
    assign mem_req       = cmd;
    assign mem_addr      = mem_write_req ? {rd_tag, idx} : (mem_read_req ? addr_q : '0);
    assign mem_wdata     = mem_write_req ? rd_data : '0;
endmodule

// File: tb/tb_proc_cache_requester.sv
// tb_proc_cache_requester: directed vectors plus randomized requests checked against a
// line-level reference model and a behavioural memory with programmable latency.
module tb_proc_cache_requester;
    localparam int NL = 8, AW = 14, DW = 16, TMO = 64;

    logic clk = 0, reset_n = 0;
    logic cpu_valid = 0, cpu_we = 0;
    logic [AW-1:0] cpu_addr = 0;
    logic [DW-1:0] cpu_wdata = 0;
    logic cpu_ready, cpu_done, cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic mem_req, mem_read_req, mem_write_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic mem_resp;

    always #5 clk = ~clk;

    proc_cache_requester #(.NUM_LINES(NL), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .mem_req(mem_req), .mem_read_req(mem_read_req),
        .mem_write_req(mem_write_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} txn_t;

    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rmem [1 << AW];
    txn_t log_q [$];
    int mem_lat = 1;

    // Memory: responds after mem_lat request cycles with a one-cycle mem_resp; 0 = never.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_resp = 0;
        mem_rdata = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;
        mem[5] = 16'h1234;
        forever begin
            @(negedge clk);
            if (mem_resp) begin
                mem_resp = 0;
                wcnt = 0;
            end else if (mem_req) begin
                wcnt++;
                if (mem_lat != 0 && wcnt >= mem_lat) begin
                    mem_resp = 1;
                    if (mem_write_req) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                    log_q.push_back(txn_t'{mem_write_req, mem_addr, mem_write_req ? mem_wdata : mem[mem_addr]});
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    int req_cycles = 0, done_cnt = 0, viol = 0;
    logic p_req = 0, p_r = 0;
    logic [AW-1:0] p_a = 0;
    logic [DW-1:0] p_d = 0;
    always @(negedge clk) begin
        if (mem_req) req_cycles++;
        if (cpu_done) done_cnt++;
        if ((mem_read_req && mem_write_req) || mem_req != (mem_read_req || mem_write_req)) viol++;
        if (p_req && mem_req && (p_r != mem_read_req || p_a != mem_addr || p_d != mem_wdata)) viol++;
        p_req = mem_req;
        p_r = mem_read_req;
        p_a = mem_addr;
        p_d = mem_wdata;
    end

    // Reference model: 0 = invalid, 1 = clean, 2 = dirty.
    int m_st [NL];
    int m_tg [NL];
    logic [DW-1:0] m_dt [NL];

    task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat,
                       output logic [DW-1:0] rd, output logic er, output int ntx);
        int idx, tg, rc0, n0, cyc, w;
        bit hit;
        logic [AW-1:0] va;
        logic [DW-1:0] e_rd;
        logic e_er;
        txn_t exp_q [$];
        idx = int'(a) % NL;
        tg = int'(a) / NL;
        hit = m_st[idx] != 0 && m_tg[idx] == tg;
        e_er = 0;
        e_rd = 0;
        if (hit) begin
            if (we) begin
                m_dt[idx] = d;
                m_st[idx] = 2;
            end else e_rd = m_dt[idx];
        end else if (lat == 0) begin
            e_er = 1;
            if (m_st[idx] != 2) m_st[idx] = 0;
        end else begin
            va = AW'(m_tg[idx] * NL + idx);
            if (m_st[idx] == 2) begin
                exp_q.push_back(txn_t'{1'b1, va, m_dt[idx]});
                rmem[va] = m_dt[idx];
            end
            exp_q.push_back(txn_t'{1'b0, a, rmem[a]});
            m_tg[idx] = tg;
            m_st[idx] = we ? 2 : 1;
            m_dt[idx] = we ? d : rmem[a];
            e_rd = rmem[a];
        end
        mem_lat = lat;
        n0 = log_q.size();
        rc0 = req_cycles;
        w = 0;
        while (!cpu_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", cpu_ready, 1);
        cpu_valid = 1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_valid = 0;
        cpu_we = 1'($urandom);
        cpu_addr = AW'($urandom);
        cpu_wdata = DW'($urandom);
        check("ready_drop", cpu_ready, 0);
        cyc = 1;
        while (!cpu_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", cpu_done, 1);
        rd = cpu_rdata;
        er = cpu_err;
        check("cpu_err", er, e_er);
        if (!we) check("cpu_rdata", rd, e_rd);
        ntx = log_q.size() - n0;
        check("txn_count", ntx, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ntx; i++) begin
            check("txn_write", log_q[n0 + i].w, exp_q[i].w);
            check("txn_addr", log_q[n0 + i].a, exp_q[i].a);
            check("txn_data", log_q[n0 + i].d, exp_q[i].d);
        end
        if (hit) check("hit_latency", cyc, 2);
        if (hit) check("hit_no_req", req_cycles - rc0, 0);
        if (!hit && lat == 0) check("timeout_req_cycles", req_cycles - rc0, TMO);
        @(negedge clk);
        check("done_one_cycle", cpu_done, 0);
        check("ready_after_done", cpu_ready, 1);
    endtask

    typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] d; int lat; logic [DW-1:0] rd; logic er; int ntx;} vec_t;

    initial begin
        vec_t vt [9];
        logic [DW-1:0] rd;
        logic er;
        int ntx, dc0;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) rmem[i] = DW'(i) ^ 16'h5A5A;
        rmem[5] = 16'h1234;
        for (int i = 0; i < NL; i++) begin
            m_st[i] = 0;
            m_tg[i] = 0;
            m_dt[i] = 0;
        end
        vt[0] = '{1'b0, 14'h0005, 16'h0000, 10, 16'h1234, 1'b0, 1};
        vt[1] = '{1'b0, 14'h0005, 16'h0000, 10, 16'h1234, 1'b0, 0};
        vt[2] = '{1'b1, 14'h0005, 16'hBEEF, 10, 16'h0000, 1'b0, 0};
        vt[3] = '{1'b0, 14'h0005, 16'h0000, 10, 16'hBEEF, 1'b0, 0};
        vt[4] = '{1'b0, 14'h000D, 16'h0000, 3,  16'h5A57, 1'b0, 2};
        vt[5] = '{1'b0, 14'h0005, 16'h0000, 1,  16'hBEEF, 1'b0, 1};
        vt[6] = '{1'b0, 14'h0002, 16'h0000, 0,  16'h0000, 1'b1, 0};
        vt[7] = '{1'b0, 14'h0002, 16'h0000, 2,  16'h5A58, 1'b0, 1};
        vt[8] = '{1'b1, 14'h0003, 16'hCAFE, 1,  16'h0000, 1'b0, 1};

        repeat (3) @(negedge clk);
        check("rst_ready", cpu_ready, 1);
        check("rst_cpu", {cpu_done, cpu_err, cpu_rdata}, 0);
        check("rst_mem", {mem_req, mem_read_req, mem_write_req, mem_addr, mem_wdata}, 0);
        reset_n = 1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            req(vt[i].we, vt[i].a, vt[i].d, vt[i].lat, rd, er, ntx);
            if (!vt[i].we) check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            check($sformatf("vec%0d_err", i), er, vt[i].er);
            check($sformatf("vec%0d_ntx", i), ntx, vt[i].ntx);
        end

        // Reset in the middle of a fill that memory never answers.
        mem_lat = 0;
        cpu_valid = 1;
        cpu_we = 0;
        cpu_addr = 14'h0004;
        @(negedge clk);
        cpu_valid = 0;
        repeat (5) @(negedge clk);
        check("midfill_req", {mem_req, mem_read_req, mem_write_req}, 3'b110);
        dc0 = done_cnt;
        reset_n = 0;
        @(negedge clk);
        check("midfill_rst_mem", {mem_req, mem_read_req, mem_write_req, mem_addr, mem_wdata}, 0);
        check("midfill_rst_ready", cpu_ready, 1);
        check("midfill_rst_done", cpu_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (TMO + 5) @(negedge clk);
        check("midfill_no_done", done_cnt - dc0, 0);
        for (int i = 0; i < NL; i++) m_st[i] = 0;
        req(1'b0, 14'h0005, 16'h0, 2, rd, er, ntx);
        check("post_rst_line5_miss", ntx, 1);
        req(1'b0, 14'h0003, 16'h0, 2, rd, er, ntx);
        check("post_rst_line3_no_wb", ntx, 1);
        check("post_rst_line3_data", rd, 16'h5A59);

        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3) * NL + $urandom_range(0, NL - 1));
            req(1'($urandom), a, DW'($urandom), ($urandom_range(0, 30) == 0) ? 0 : int'($urandom_range(1, 5)), rd, er, ntx);
        end

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/proc_cache_requester.md
Name: proc_cache_requester

Overview:
Processor-side initiator for memory_subsystem: a small direct-mapped, write-back, one-word-per-line cache with I/S/M line state. It accepts CPU loads and stores. On a miss it drives the processor_req_N / mem_read_req / mem_write_req / addr / mem_write_data handshake toward memory and waits for processor_resp_N. One instance exists per processor (N = 0..3).

Parameters:
NUM_LINES, 8, cache lines; power of two, 2..64
ADDR_W, 14, word address width; matches memory addr
DATA_W, 16, word width; matches DATA_SIZE*8
TIMEOUT, 64, cycles to wait for mem_resp before declaring error; must be ≥ 2

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
cpu_valid  in  1  CPU request; sampled only when cpu_ready=1
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  store data
cpu_ready  out  1  block idle, can accept request
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data; valid with cpu_done on a load
cpu_err  out  1  valid with cpu_done; 1 = memory timeout
mem_req  out  1  to processor_req_N
mem_read_req  out  1  read command
mem_write_req  out  1  write command
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  from processor_resp_N

Behaviour:
- Reset (reset_n=0 at a clk edge): all line states I; tags and data don't-care; FSM to IDLE. Outputs: cpu_ready=1, cpu_done=0, cpu_err=0, cpu_rdata=0, mem_req=0, mem_read_req=0, mem_write_req=0, mem_addr=0, mem_wdata=0. Reset aborts any in-flight transaction: no writeback and no cpu_done for it.
- Address split: index = cpu_addr[log2(NUM_LINES)-1:0]; tag = the remaining upper bits. Hit = state != I and tag match.
- FSM states: IDLE, LOOKUP, WB, FILL, DONE.
- IDLE: cpu_ready=1. cpu_valid=1 latches we/addr/wdata and moves to LOOKUP; cpu_ready drops the next cycle.
- LOOKUP, load hit: cpu_rdata = line data; go to DONE. Cycle count: accept edge N, cpu_done high in cycle N+2.
- LOOKUP, store hit: write line data; state becomes M regardless of S or M; no memory traffic; go to DONE.
- LOOKUP, miss with victim M: go to WB. Miss with victim I or S: go to FILL. An S victim is dropped silently.
- WB: drive mem_req=1, mem_write_req=1, mem_addr={victim tag, index}, mem_wdata=victim data. Hold all stable until mem_resp=1 is sampled. Next cycle: deassert all, mark victim I, go to FILL.
- FILL: drive mem_req=1, mem_read_req=1, mem_addr=latched addr; hold until mem_resp=1. Capture mem_rdata in the mem_resp cycle and install the tag.
  - Load: state S, cpu_rdata = fill data.
  - Store: line data = cpu_wdata, state M.
  - Go to DONE.
- mem_read_req and mem_write_req are never both 1. mem_req equals their OR. Commands are deasserted at least one cycle between transactions.
- DONE: cpu_done=1 for one cycle, then IDLE with cpu_ready=1. New requests are accepted only from IDLE; there are no back-to-back accepts.
- Timeout: a counter clears on entry to WB or FILL and increments each waiting cycle. On reaching TIMEOUT-1 without mem_resp: deassert mem_* and go to DONE with cpu_err=1 and cpu_rdata=0.
  - Line state after a timeout: WB timeout leaves the victim M and unchanged; FILL timeout leaves the target I.
- mem_resp seen in IDLE, LOOKUP or DONE is ignored.
- A single-cycle mem_resp is sufficient. A held mem_resp counts once per transaction, because commands are deasserted after the first sampled cycle.

Decomposition:
- Shared package (mem_pkg):
  - coherency_t enum: I=2'b00, M=2'b01, S=2'b10. Identical encoding to memory_subsystem.
  - Constants ADDR_W=14, DATA_W=16.
  - cache_fsm_t enum.
- Sub-module cache_line_array: tag/data/state storage with one read port and one write port, combinational read, synchronous write, synchronous reset of state to I. FSM, handshake and timeout logic stay in the top.

Test Plan:
- Reset, then load 0x0005 with memory model returning 0x1234 at latency 10 → one read transaction, mem_addr=0x0005; cpu_done with cpu_rdata=0x1234, cpu_err=0; line 5 in S.
- Repeat load 0x0005 → no mem_req asserted; cpu_done exactly 2 cycles after accept, rdata=0x1234.
- Store 0xBEEF to 0x0005 (S hit) → no memory traffic; line 5 in M; subsequent load returns 0xBEEF.
- Load 0x000D (same index, new tag) → WB with mem_addr=0x0005, mem_wdata=0xBEEF, then FILL mem_addr=0x000D; never both read and write asserted; final line state S.
- Memory model never responds to a load miss at 0x0002 → mem_req held exactly TIMEOUT cycles, then cpu_done with cpu_err=1, cpu_rdata=0; line 2 in I; the next request is accepted.
- Assert reset_n=0 mid-FILL → all mem_* outputs 0 the next cycle; no cpu_done; all lines I; cpu_ready=1.
